// File: rtl/dcache_tag_array_nway.sv
`default_nettype none
// ============================================================================
// Module  : dcache_tag_array_nway
// Purpose : N-way dcache tag store with lookup/hit/victim and invalidate sweep
// Revision: 1.0
// ============================================================================
module dcache_tag_array_nway #(
  parameter int NUM_WAYS  = 4,
  parameter int NUM_WORDS = 256,
  parameter int TAG_W     = 20
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  output logic                                 busy_o,
  input  logic                                 req_i,
  input  logic                                 we_i,
  input  logic [$clog2(NUM_WORDS)-1:0]         addr_i,
  input  logic [TAG_W-1:0]                     tag_i,
  input  logic [NUM_WAYS-1:0]                  wway_i,
  input  logic [TAG_W-1:0]                     wtag_i,
  input  logic                                 wvalid_i,
  input  logic                                 wdirty_i,
  input  logic [2:0]                           wfield_en_i,
  output logic                                 rvalid_o,
  output logic                                 hit_o,
  output logic [NUM_WAYS-1:0]                  hit_way_o,
  output logic [NUM_WAYS*(TAG_W+2)-1:0]        rdata_o,
  output logic [NUM_WAYS-1:0]                  victim_way_o
);

  localparam int c_IDX_W = $clog2(NUM_WORDS);
  localparam int c_E     = TAG_W + 2;
  localparam int c_RR_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [0:0] c_SWEEP = 1'b0;
  localparam logic [0:0] c_IDLE  = 1'b1;

  logic [0:0]                r_state;
  logic [c_IDX_W-1:0]        r_cnt;
  logic [c_RR_W-1:0]         r_rr_ptr;

  logic                      w_busy;
  logic                      w_rd_en;
  logic                      w_wr_en;
  logic                      w_fill;
  logic [NUM_WAYS-1:0]       w_valid_rd;
  logic [NUM_WAYS-1:0]       w_hit_way;
  logic [NUM_WAYS*c_E-1:0]   w_rdata;

  assign w_busy  = (r_state == c_SWEEP);
  assign busy_o  = w_busy;
  assign w_rd_en = req_i & ~w_busy & ~rst_i;
  assign w_wr_en = we_i & ~w_busy & ~rst_i;
  assign w_fill  = w_wr_en & (|wway_i) & wfield_en_i[2] & wfield_en_i[1] & wvalid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= c_SWEEP;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        c_SWEEP: begin
          if (r_cnt == c_IDX_W'(NUM_WORDS - 1)) r_state <= c_IDLE;
          r_cnt <= r_cnt + 1'b1;
        end
        default: begin
          if (flush_i) begin
            r_state <= c_SWEEP;
            r_cnt   <= '0;
          end
        end
      endcase
      if (w_fill) begin
        if (r_rr_ptr == c_RR_W'(NUM_WAYS - 1)) r_rr_ptr <= '0;
        else                                   r_rr_ptr <= r_rr_ptr + 1'b1;
      end
    end
  end

  // Each way keeps its fields in separate arrays so per-field write enables are plain.
  for (genvar gw = 0; gw < NUM_WAYS; gw++) begin : g_way
    logic [TAG_W-1:0]     r_tag_mem [NUM_WORDS];
    logic [NUM_WORDS-1:0] r_valid_mem;
    logic [NUM_WORDS-1:0] r_dirty_mem;

    always_ff @(posedge clk_i) begin
      if (w_busy) begin
        r_valid_mem[r_cnt] <= 1'b0;
        r_dirty_mem[r_cnt] <= 1'b0;
      end else if (w_wr_en && wway_i[gw]) begin
        if (wfield_en_i[2]) r_tag_mem[addr_i]   <= wtag_i;
        if (wfield_en_i[1]) r_valid_mem[addr_i] <= wvalid_i;
        if (wfield_en_i[0]) r_dirty_mem[addr_i] <= wdirty_i;
      end
    end

    assign w_valid_rd[gw]           = r_valid_mem[addr_i];
    assign w_rdata[gw*c_E +: c_E]   = {r_valid_mem[addr_i], r_dirty_mem[addr_i], r_tag_mem[addr_i]};
    assign w_hit_way[gw]            = r_valid_mem[addr_i] & (r_tag_mem[addr_i] == tag_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o  <= 1'b0;
      hit_o     <= 1'b0;
      hit_way_o <= '0;
      rdata_o   <= '0;
    end else begin
      rvalid_o <= w_rd_en;
      if (w_rd_en) begin
        hit_o     <= |w_hit_way;
        hit_way_o <= w_hit_way;
        rdata_o   <= w_rdata;
      end
    end
  end

  if (NUM_WAYS == 1) begin : g_victim_single
    assign victim_way_o = 1'b1;
  end else begin : g_victim_multi
    logic [NUM_WAYS-1:0] w_victim;
    logic [NUM_WAYS-1:0] r_victim;

    // Lowest invalid way wins; a full set falls back to the round-robin pointer.
    always_comb begin
      w_victim           = '0;
      w_victim[r_rr_ptr] = 1'b1;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
        if (!w_valid_rd[w]) begin
          w_victim    = '0;
          w_victim[w] = 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i)        r_victim <= '0;
      else if (w_rd_en) r_victim <= w_victim;
    end

    assign victim_way_o = r_victim;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && rvalid_o) assert ($onehot0(hit_way_o));
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_tag_array_nway.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcache_tag_array_nway
// Purpose : directed self-checking bench for dcache_tag_array_nway
// Revision: 1.0
// ============================================================================
module tb_dcache_tag_array_nway;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, req_i, we_i, wvalid_i, wdirty_i;
  logic [7:0]  addr_i;
  logic [19:0] tag_i, wtag_i;
  logic [3:0]  wway_i;
  logic [2:0]  wfield_en_i;
  logic        busy_o, rvalid_o, hit_o;
  logic [3:0]  hit_way_o, victim_way_o;
  logic [87:0] rdata_o;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int exp_rr = 0;
  int cycles;
  logic [3:0] one = 4'b0001;

  dcache_tag_array_nway #(.NUM_WAYS(4), .NUM_WORDS(256), .TAG_W(20)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .busy_o(busy_o),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .tag_i(tag_i),
    .wway_i(wway_i), .wtag_i(wtag_i), .wvalid_i(wvalid_i), .wdirty_i(wdirty_i),
    .wfield_en_i(wfield_en_i), .rvalid_o(rvalid_o), .hit_o(hit_o),
    .hit_way_o(hit_way_o), .rdata_o(rdata_o), .victim_way_o(victim_way_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [87:0] obs, input logic [87:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [21:0] ent(input int w);
    return rdata_o[w*22 +: 22];
  endfunction

  function automatic logic [7:0] vd();
    logic [7:0] r;
    for (int w = 0; w < 4; w++) r[w*2 +: 2] = rdata_o[w*22+20 +: 2];
    return r;
  endfunction

  task automatic write(input logic [7:0] a, input logic [3:0] way, input logic [19:0] t,
                       input logic v, input logic d, input logic [2:0] f);
    addr_i = a; wway_i = way; wtag_i = t; wvalid_i = v; wdirty_i = d; wfield_en_i = f;
    we_i = 1'b1;
    tick();
    we_i = 1'b0;
    if (way != 0 && f[2] && f[1] && v) exp_rr = (exp_rr + 1) % 4;
  endtask

  task automatic lookup(input logic [7:0] a, input logic [19:0] t);
    addr_i = a; tag_i = t; req_i = 1'b1;
    tick();
    req_i = 1'b0;
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (busy_o && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; req_i = 1'b0; we_i = 1'b0; wvalid_i = 1'b0;
    wdirty_i = 1'b0; addr_i = '0; tag_i = '0; wtag_i = '0; wway_i = '0; wfield_en_i = '0;
    tick(); tick();
    chk("reset_ctl", {busy_o, rvalid_o, hit_o, hit_way_o, victim_way_o}, {3'b100, 8'h00});
    chk("reset_rdata", rdata_o, 88'h0);
    rst_i = 1'b0;
    wait_sweep(cycles);
    chk("sweep_len_reset", cycles, 256);

    // First lookup after sweep: everything invalid
    lookup(8'h33, 20'h0);
    chk("first_lookup", {rvalid_o, hit_o, hit_way_o, victim_way_o}, {2'b10, 4'b0000, 4'b0001});
    chk("first_vd", vd(), 8'h00);
    tick();
    chk("rvalid_pulse", {rvalid_o, victim_way_o}, {1'b0, 4'b0001});

    // Fill set 0x12 way 2
    write(8'h12, 4'b0100, 20'hABCDE, 1'b1, 1'b0, 3'b110);
    lookup(8'h12, 20'hABCDE);
    chk("fill_hit", {rvalid_o, hit_o, hit_way_o, victim_way_o}, {2'b11, 4'b0100, 4'b0001});
    chk("fill_entry", ent(2), {2'b10, 20'hABCDE});

    // Dirty-only write leaves tag and valid alone
    write(8'h12, 4'b0100, 20'h11111, 1'b0, 1'b1, 3'b001);
    lookup(8'h12, 20'hABCDE);
    chk("dirty_entry", ent(2), {2'b11, 20'hABCDE});
    chk("dirty_hit", hit_o, 1'b1);
    lookup(8'h12, 20'hABCDF);
    chk("tag_miss", {hit_o, hit_way_o}, 5'b0_0000);

    // Fill set 5 way by way; victim follows lowest invalid way
    for (int i = 0; i < 4; i++) begin
      lookup(8'h05, 20'h0);
      chk("fill_victim", victim_way_o, one << i);
      write(8'h05, one << i, 20'h50 + 20'(i), 1'b1, 1'b0, 3'b110);
    end
    lookup(8'h05, 20'h52);
    chk("full_hit_way", hit_way_o, 4'b0100);
    chk("full_victim", victim_way_o, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      write(8'h05, 4'b0001, 20'h50, 1'b1, 1'b0, 3'b110);
      lookup(8'h05, 20'h50);
      chk("rr_victim", victim_way_o, one << exp_rr);
    end

    // Read-first on simultaneous read/write, then back-to-back lookups
    write(8'h07, 4'b0001, 20'h77777, 1'b1, 1'b0, 3'b111);
    addr_i = 8'h07; tag_i = 20'h77777; req_i = 1'b1; we_i = 1'b1;
    wway_i = 4'b0001; wtag_i = 20'h12345; wvalid_i = 1'b1; wdirty_i = 1'b1; wfield_en_i = 3'b111;
    tick();
    we_i = 1'b0;
    exp_rr = (exp_rr + 1) % 4;
    chk("rf_old_entry", ent(0), {2'b10, 20'h77777});
    chk("rf_old_hit", hit_way_o, 4'b0001);
    tag_i = 20'h12345;
    tick();
    chk("rf_new_entry", {rvalid_o, ent(0)}, {3'b111, 20'h12345});
    chk("rf_new_hit", hit_way_o, 4'b0001);
    addr_i = 8'h12; tag_i = 20'hABCDE;
    tick();
    req_i = 1'b0;
    chk("b2b_second", {rvalid_o, hit_way_o}, 5'b1_0100);
    write(8'h12, 4'b0100, 20'h0, 1'b0, 1'b0, 3'b001);
    chk("hold_outputs", {rvalid_o, hit_way_o, ent(2)}, {1'b0, 4'b0100, 2'b11, 20'hABCDE});

    // Flush, drop traffic during sweep, reset mid-sweep
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 1'b1);
    addr_i = 8'h12; tag_i = 20'hABCDE; req_i = 1'b1;
    tick();
    req_i = 1'b0;
    chk("sweep_no_rvalid", rvalid_o, 1'b0);
    addr_i = 8'h12; wway_i = 4'b0100; wtag_i = 20'h0; wvalid_i = 1'b1; wdirty_i = 1'b1;
    wfield_en_i = 3'b111; we_i = 1'b1;
    tick();
    we_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    repeat (97) tick();
    chk("busy_at_100", busy_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_rr = 0;
    wait_sweep(cycles);
    chk("sweep_len_midrst", cycles, 256);

    lookup(8'h12, 20'hABCDE);
    chk("post_flush_12", {hit_o, ent(2)}, {3'b000, 20'hABCDE});
    lookup(8'h07, 20'h12345);
    chk("post_flush_07", {hit_o, victim_way_o, ent(0)}, {1'b0, 4'b0001, 2'b00, 20'h12345});
    lookup(8'h05, 20'h0);
    chk("post_flush_vd5", vd(), 8'h00);
    chk("post_flush_tag5", ent(3), {2'b00, 20'h53});
    for (int i = 0; i < 4; i++) write(8'h05, one << i, 20'h60 + 20'(i), 1'b1, 1'b1, 3'b111);
    lookup(8'h05, 20'h61);
    chk("refill_hit", {hit_o, hit_way_o, ent(1)}, {1'b1, 4'b0010, 2'b11, 20'h61});
    chk("refill_victim", victim_way_o, one << exp_rr);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
